fsm_cmd_arbiter: RTL
====================

Name: fsm_cmd_arbiter

Overview:
- Shares one Mealy command FSM (2-bit command in, 2-bit combinational output) among NUM_REQ requesters.
- Arbitrates, grants one requester a bounded burst of commands, and drives the shared FSM's command input.
- Samples the FSM's output in the issue cycle and returns it as a registered, tagged response.
- Sits between requester blocks and the shared FSM instance; the only driver of that FSM's input.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- HOLD_CYCLES, 3, max commands issued per grant (1..15).
- PARK_CMD, 2'h3, command driven while nobody is served; the shared FSM holds state on it.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- req  in  NUM_REQ  per-requester request; held high while the requester has commands.
- cmd  in  2*NUM_REQ  per-requester command; requester i uses bits [2i+1:2i].
- gnt  out  NUM_REQ  one-hot grant, registered.
- fsm_in  out  2  command to the shared FSM.
- fsm_out  in  2  combinational output of the shared FSM.
- rsp_valid  out  1  response strobe, one cycle per issued command.
- rsp_data  out  2  fsm_out sampled in the issue cycle.
- rsp_id  out  $clog2(NUM_REQ)  index of the issuing requester.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, gnt=0, rsp_valid=0, rsp_data=0, rsp_id=0, rr_ptr=0, issue_cnt=0.
  - fsm_in=PARK_CMD combinationally while state!=SERVE.
- States:
  - IDLE: gnt=0. If any req bit is set, pick the winner w by round-robin starting at rr_ptr. Next: SERVE with gnt=onehot(w), issue_cnt=0. Otherwise stay in IDLE.
  - SERVE: gnt[w]=1.
    - If req[w]=1: issue cycle. fsm_in=cmd[w]; issue_cnt increments. Next cycle: rsp_valid=1, rsp_data=fsm_out as sampled, rsp_id=w.
    - If req[w]=0: fsm_in=PARK_CMD, no issue, next state RELEASE.
    - If the issue makes issue_cnt reach HOLD_CYCLES: next state RELEASE.
  - RELEASE: gnt=0, fsm_in=PARK_CMD, rr_ptr=(w+1) mod NUM_REQ. Next: IDLE. This is one bubble cycle, so another requester can always be picked on the following IDLE cycle.
- Latency:
  - req rise to first gnt: 1 cycle.
  - Issue to rsp_valid: 1 cycle.
  - Minimum grant-to-grant turnaround: 3 cycles (last SERVE, RELEASE, IDLE).
- Boundary conditions:
  - Fairness: requester w cannot be regranted while another requester is waiting.
  - Requester alone: it is regranted after RELEASE, IDLE.
  - req[w] deasserting in the first SERVE cycle: zero commands issued, no rsp.
  - HOLD_CYCLES=1: exactly one issue per grant.
  - Non-winner req changes during SERVE: ignored.
  - rr_ptr wraps from NUM_REQ-1 to 0.
  - Reset mid-SERVE: burst abandoned. The response of an issue in the reset cycle is dropped (rsp_valid=0 after reset).
- Invariants:
  - At most one gnt bit set.
  - fsm_in never equals a requester cmd outside an issue cycle.

Optional Feature:
- Macro: FSM_CMD_ARB_FIXED_PRIO_EN.
- Defined:
  - IDLE picks the lowest-index requesting bit (requester 0 highest priority).
  - rr_ptr is not implemented.
  - The RELEASE bubble still occurs.
- Undefined: round-robin as above.

Decomposition:
- Package fsm_cmd_arb_pkg holds:
  - arb_state_t enum (IDLE, SERVE, RELEASE; 2-bit logic).
  - PARK_CMD default constant.
  - Function rr_pick(req, ptr) returning the winner index.
- One natural sub-module, fsm_cmd_rr_picker: combinational rotate, priority encode, unrotate. It is instantiated once and bypassed under FSM_CMD_ARB_FIXED_PRIO_EN.

Test Plan:
- Reset: hold rst_n=0 two cycles with req=4'hF -> gnt=0, rsp_valid=0, fsm_in=2'h3 throughout.
- Single burst, with the shared FSM starting in Red:
  - Stimulus: req=4'b0001, cmd0=2'h1 for 3 cycles.
  - Expected: gnt=4'b0001 one cycle after req. rsp sequence (2'h1,id0), (2'h2,id0), (2'h1,id0). Then RELEASE, gnt=0.
- Round-robin:
  - Stimulus: req=4'b1011 held constant.
  - Expected: grant order 0,1,3,0, each with 3 rsps and a 2-cycle gap between grants.
- Early drop:
  - Stimulus: req[2] high, dropped after 1 issue.
  - Expected: exactly one rsp with id2, then RELEASE, and fsm_in=2'h3 from the drop cycle.
- Reset mid-SERVE: assert rst_n=0 on the 2nd issue cycle -> no rsp follows, state IDLE, rr_ptr=0.
- Fixed-priority build (FSM_CMD_ARB_FIXED_PRIO_EN):
  - Stimulus: req=4'b1011 held constant.
  - Expected: requester 0 regranted repeatedly; requester 3 never granted while req[0]=1.

Source files
------------

// File: rtl/fsm_cmd_arb_pkg.sv
// Purpose : shared types, constants and the round-robin helper for fsm_cmd_arbiter.
// Latency : n/a (types, constants and a combinational function only).
// Backpressure: n/a.
// Contents: arb_state_t, PARK_CMD_DEFAULT, rr_pick(req, ptr).
package fsm_cmd_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE   = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  // Command that leaves the shared FSM in its current state.
  localparam logic [1:0] PARK_CMD_DEFAULT = 2'h3;

  // Winner index scanning upward from ptr with wrap. The request vector is
  // zero-padded to 8 bits, so wrapping through the unused upper positions
  // behaves exactly like a modulo-NUM_REQ scan for any NUM_REQ <= 8.
  function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr);
    logic [2:0] idx;
    logic [2:0] win;
    logic       found;
    win   = ptr;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idx = ptr + i[2:0];
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/fsm_cmd_rr_picker.sv
// Purpose : round-robin winner select: rotate req by ptr, priority encode, unrotate.
// Latency : combinational.
// Backpressure: none; any=0 when no requester is asking.
// Ports   : req (request vector), ptr (highest-priority index), any (some req set), win (winner index).
module fsm_cmd_rr_picker #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic                       any,
  output logic [$clog2(NUM_REQ)-1:0] win
);
  localparam int          IW  = $clog2(NUM_REQ);
  localparam logic [IW:0] N_W = (IW + 1)'(NUM_REQ);

  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [IW-1:0]        off;
  logic [IW:0]          sum;
  logic                 found;

  // Doubling the vector turns the rotation into a plain part-select.
  assign dbl = {req, req};
  assign any = |req;

  always_comb begin
    rot   = dbl[ptr +: NUM_REQ];
    off   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && rot[i]) begin
        off   = i[IW-1:0];
        found = 1'b1;
      end
    end
    // Unrotate: (ptr + off) mod NUM_REQ without a divider.
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= N_W) begin
      sum = sum - N_W;
    end
    win = sum[IW-1:0];
  end

endmodule

// File: rtl/fsm_cmd_arbiter.sv
// Purpose : time-shares one Mealy command FSM among NUM_REQ requesters in bounded bursts.
// Latency : req->gnt 1 cycle; issue->rsp 1 cycle; grant-to-grant minimum 3 cycles.
// Backpressure: a requester issues only while granted and holding req; dropping req ends the burst.
// Ports   : clk, rst_n (sync, active-low); req/cmd per requester; gnt one-hot;
//           fsm_in/fsm_out to/from the shared FSM; rsp_valid/rsp_data/rsp_id tagged response.
// Build   : define FSM_CMD_ARB_FIXED_PRIO_EN for fixed priority (requester 0 highest), no rr_ptr.
module fsm_cmd_arbiter
  import fsm_cmd_arb_pkg::*;
#(
  parameter int         NUM_REQ     = 4,
  parameter int         HOLD_CYCLES = 3,
  parameter logic [1:0] PARK_CMD    = PARK_CMD_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [2*NUM_REQ-1:0]       cmd,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [1:0]                 fsm_in,
  input  logic [1:0]                 fsm_out,
  output logic                       rsp_valid,
  output logic [1:0]                 rsp_data,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id
);
  localparam int            IW        = $clog2(NUM_REQ);
  localparam logic [3:0]    HOLD_LAST = 4'(HOLD_CYCLES - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_REQ - 1);

  arb_state_t    state;
  arb_state_t    state_nxt;
  logic [IW-1:0] win_q;
  logic [IW-1:0] pick;
  logic          pick_vld;
  logic [3:0]    issue_cnt;
  logic          issue;

`ifdef FSM_CMD_ARB_FIXED_PRIO_EN
  // Scanning from index 0 every time gives plain lowest-index priority.
  assign pick     = IW'(rr_pick(8'(req), 3'd0));
  assign pick_vld = |req;
`else
  logic [IW-1:0] rr_ptr;

  fsm_cmd_rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req (req),
    .ptr (rr_ptr),
    .any (pick_vld),
    .win (pick)
  );
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. The HOLD_LAST test only matters on an issue cycle,
  // which is guaranteed here because a low req takes the first branch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_vld) state_nxt = SERVE;
      SERVE:   if (!req[win_q] || (issue_cnt == HOLD_LAST)) state_nxt = RELEASE;
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs to the shared FSM: a requester command reaches it only on an
  // issue cycle; every other cycle parks it.
  always_comb begin
    issue  = 1'b0;
    fsm_in = PARK_CMD;
    if ((state == SERVE) && req[win_q]) begin
      issue  = 1'b1;
      fsm_in = cmd[{win_q, 1'b0} +: 2];
    end
  end

  // Grant, burst counter, pointer and the registered response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt       <= '0;
      win_q     <= '0;
      issue_cnt <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
`ifndef FSM_CMD_ARB_FIXED_PRIO_EN
      rr_ptr    <= '0;
`endif
    end else begin
      rsp_valid <= issue;
      if (issue) begin
        rsp_data  <= fsm_out;
        rsp_id    <= win_q;
        issue_cnt <= issue_cnt + 4'd1;
      end
      if ((state == IDLE) && pick_vld) begin
        win_q     <= pick;
        gnt       <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick;
        issue_cnt <= '0;
      end
      if ((state == SERVE) && (state_nxt != SERVE)) begin
        gnt <= '0;
      end
`ifndef FSM_CMD_ARB_FIXED_PRIO_EN
      if (state == RELEASE) begin
        rr_ptr <= (win_q == LAST_IDX) ? '0 : win_q + IW'(1);
      end
`endif
    end
  end

endmodule
